// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision multiply sequencer:
// field positions, exponent constants, controller states and operand screens.
package fp_pkg;

   localparam int         BIAS     = 127;
   localparam logic [7:0] EXP_MAX  = 8'hFF;
   localparam int         SIGN_BIT = 31;
   localparam int         EXP_HI   = 30;
   localparam int         EXP_LO   = 23;
   localparam int         MAN_HI   = 22;
   localparam int         MAN_LO   = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_MULT,
      ST_NORM,
      ST_DONE
   } state_t;

   function automatic logic is_zero(input logic [31:0] x);
      return (x[EXP_HI:EXP_LO] == 8'h00) && (x[MAN_HI:MAN_LO] == 23'h0);
   endfunction

   // Inf/NaN and denormals are both rejected by this datapath.
   function automatic logic is_special(input logic [31:0] x);
      return (x[EXP_HI:EXP_LO] == EXP_MAX) ||
             ((x[EXP_HI:EXP_LO] == 8'h00) && (x[MAN_HI:MAN_LO] != 23'h0));
   endfunction

endpackage

// File: rtl/fp_mul_seq_ctrl_if.sv
// Operand/result handshake bundle between the ALU dispatcher (master)
// and the multiply sequencer (slave).
interface fp_mul_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] r;
   logic        exception;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, r, exception
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, r, exception
   );
endinterface

// File: rtl/fp_mant_mul_iter.sv
// Iterative shift-add 24x24 mantissa multiplier, BITS_PER_CYCLE multiplier
// bits per clock. done_o flags the cycle whose edge writes the final product.
module fp_mant_mul_iter #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [23:0] ma_i,
   input  logic [23:0] mb_i,
   output logic        done_o,
   output logic [24:0] prod_o
);

   localparam int unsigned N_ITER = 24 / BITS_PER_CYCLE;

   if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 3 ||
         BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 6 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
      $error("BITS_PER_CYCLE must be one of 1,2,3,4,6,8");
   end

   logic [4:0]  cnt_q, cnt_d;
   logic [47:0] acc_q, acc_d;
   logic [47:0] mcand_q, mcand_d;
   logic [23:0] mplr_q, mplr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      if (start_i) begin
         cnt_d   = 5'(N_ITER);
         acc_d   = '0;
         mcand_d = {24'h0, ma_i};
         mplr_d  = mb_i;
      end else if (cnt_q != 5'd0) begin
         // Every partial term stays below 2^48, so the 48-bit sum never wraps.
         for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mplr_q[i]) acc_d = acc_d + (mcand_q << i);
         end
         mcand_d = mcand_q << BITS_PER_CYCLE;
         mplr_d  = mplr_q >> BITS_PER_CYCLE;
         cnt_d   = cnt_q - 5'd1;
      end
   end

   assign done_o = (cnt_q == 5'd1);
   assign prod_o = acc_q[47:23];

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Single-precision multiply sequencer: operand screening, iterative mantissa
// multiply, normalize/pack, and result hold until the consumer accepts.
//
// state    | meaning
// ST_IDLE  | waiting for operands, in_ready high
// ST_CHECK | screen registered operands for Inf/NaN/denormal/zero
// ST_MULT  | mantissa multiplier iterating
// ST_NORM  | normalize, range-check exponent, pack result
// ST_DONE  | out_valid high, hold r/exception until out_ready
module fp_mul_seq_ctrl
   import fp_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int          BIAS           = fp_pkg::BIAS
) (
   input  logic             clk,
   input  logic             rst,
   fp_mul_seq_ctrl_if.slave bus,
   output logic             busy_o
);

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [31:0]        r_q, r_d;
   logic               exc_q, exc_d;
   logic [9:0]         esum_q, esum_d;
   logic               mul_start, mul_done;
   logic [24:0]        p_hi;
   logic               sign;
   logic [23:0]        ma, mb;
   logic [22:0]        mant;
   logic signed [9:0]  e_norm;

   assign sign = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
   assign ma   = {1'b1, a_q[MAN_HI:MAN_LO]};
   assign mb   = {1'b1, b_q[MAN_HI:MAN_LO]};

   fp_mant_mul_iter #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mul_start),
      .ma_i    (ma),
      .mb_i    (mb),
      .done_o  (mul_done),
      .prod_o  (p_hi)
   );

   // p_hi holds p[47:23]; truncating normalization, no rounding.
   assign mant   = p_hi[24] ? p_hi[23:1] : p_hi[22:0];
   assign e_norm = $signed(esum_q) + (p_hi[24] ? 10'sd1 : 10'sd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         exc_q   <= 1'b0;
         esum_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         exc_q   <= exc_d;
         esum_q  <= esum_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      exc_d     = exc_q;
      esum_d    = esum_q;
      mul_start = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (is_special(a_q) || is_special(b_q)) begin
               exc_d   = 1'b1;
               r_d     = '0;
               state_d = ST_DONE;
            end else if (is_zero(a_q) || is_zero(b_q)) begin
               exc_d   = 1'b0;
               r_d     = {sign, 31'h0};
               state_d = ST_DONE;
            end else begin
               esum_d    = {2'b00, a_q[EXP_HI:EXP_LO]} + {2'b00, b_q[EXP_HI:EXP_LO]} - 10'(BIAS);
               mul_start = 1'b1;
               state_d   = ST_MULT;
            end
         end
         ST_MULT: begin
            if (mul_done) state_d = ST_NORM;
         end
         ST_NORM: begin
            if ((e_norm >= 10'sd255) || (e_norm <= 10'sd0)) begin
               exc_d = 1'b1;
               r_d   = '0;
            end else begin
               exc_d = 1'b0;
               r_d   = {sign, e_norm[7:0], mant};
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.r         = r_q;
   assign bus.exception = exc_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Directed bench: two sequencers (1 and 4 bits per cycle) driven in lockstep
// from a vector table, plus back-pressure and mid-operation reset sequences.
module tb_fp_mul_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;

   logic [1:0]  ov, ir, ex, bz;
   logic [31:0] rv [2];

   fp_mul_seq_ctrl_if if1 ();
   fp_mul_seq_ctrl_if if4 ();

   assign if1.in_valid  = in_valid;
   assign if1.a         = a;
   assign if1.b         = b;
   assign if1.out_ready = out_ready;
   assign if4.in_valid  = in_valid;
   assign if4.a         = a;
   assign if4.b         = b;
   assign if4.out_ready = out_ready;

   assign ov[0] = if1.out_valid;
   assign ov[1] = if4.out_valid;
   assign ir[0] = if1.in_ready;
   assign ir[1] = if4.in_ready;
   assign ex[0] = if1.exception;
   assign ex[1] = if4.exception;
   assign rv[0] = if1.r;
   assign rv[1] = if4.r;

   fp_mul_seq_ctrl #(.BITS_PER_CYCLE(1)) dut1 (
      .clk    (clk),
      .rst    (rst),
      .bus    (if1),
      .busy_o (bz[0])
   );

   fp_mul_seq_ctrl #(.BITS_PER_CYCLE(4)) dut4 (
      .clk    (clk),
      .rst    (rst),
      .bus    (if4),
      .busy_o (bz[1])
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        exc;
      bit          special;
   } vec_t;

   vec_t vecs [16];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] aa, input logic [31:0] bb);
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
      check("in_ready before accept", 32'(ir), 32'd3);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called just after the accept edge with out_ready held high.
   task automatic collect(input string name, input logic [31:0] er, input logic ee, input bit special);
      int          lat [2];
      int          wid [2];
      logic [31:0] rs  [2];
      logic        es  [2];
      for (int d = 0; d < 2; d++) begin
         lat[d] = -1;
         wid[d] = 0;
         rs[d]  = 'x;
         es[d]  = 1'bx;
      end
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (ov[d]) begin
               if (lat[d] < 0) begin
                  lat[d] = k;
                  rs[d]  = rv[d];
                  es[d]  = ex[d];
               end
               wid[d]++;
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         string dn;
         int    exp_lat;
         dn      = (d == 0) ? "B1" : "B4";
         exp_lat = special ? 1 : (2 + ((d == 0) ? 24 : 6));
         check($sformatf("%s/%s latency", name, dn), lat[d], exp_lat);
         check($sformatf("%s/%s r", name, dn), rs[d], er);
         check($sformatf("%s/%s exception", name, dn), 32'(es[d]), 32'(ee));
         check($sformatf("%s/%s valid width", name, dn), wid[d], 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{"3.0x2.0",       32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0};
      vecs[1]  = '{"1.5x-1.5",      32'h3FC00000, 32'hBFC00000, 32'hC0100000, 1'b0, 1'b0};
      vecs[2]  = '{"0x-2",          32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b1};
      vecs[3]  = '{"denormal",      32'h00000001, 32'h3F800000, 32'h00000000, 1'b1, 1'b1};
      vecs[4]  = '{"inf",           32'h7F800000, 32'h3F800000, 32'h00000000, 1'b1, 1'b1};
      vecs[5]  = '{"overflow",      32'h7F000000, 32'h40000000, 32'h00000000, 1'b1, 1'b0};
      vecs[6]  = '{"1x1",           32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
      vecs[7]  = '{"3x3",           32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0};
      vecs[8]  = '{"trunc",         32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0};
      vecs[9]  = '{"e254",          32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0};
      vecs[10] = '{"e1",            32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0};
      vecs[11] = '{"underflow",     32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 1'b0};
      vecs[12] = '{"-0x-0",         32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1};
      vecs[13] = '{"nan_x_zero",    32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
      vecs[14] = '{"e0",            32'h00800000, 32'h3F000000, 32'h00000000, 1'b1, 1'b0};
      vecs[15] = '{"norm_ovf",      32'h7F400000, 32'h3FC00000, 32'h00000000, 1'b1, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 32'(ir), 32'd3);
      check("reset out_valid", 32'(ov), 32'd0);
      check("reset exception", 32'(ex), 32'd0);
      check("reset busy", 32'(bz), 32'd0);
      check("reset r B1", rv[0], 32'h0);
      check("reset r B4", rv[1], 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         collect(vecs[i].name, vecs[i].r, vecs[i].exc, vecs[i].special);
      end

      // Back-pressure: hold DONE with a second operand pending on the input.
      begin
         int k;
         out_ready = 1'b0;
         a         = 32'h40400000;
         b         = 32'h40000000;
         in_valid  = 1'b1;
         @(posedge clk);
         #1;
         a = 32'h3FC00000;
         b = 32'hBFC00000;
         k = 0;
         while (ov != 2'b11 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
         end
         check("bp both valid", 32'(ov), 32'd3);
         for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp hold r B1", rv[0], 32'h40C00000);
            check("bp hold r B4", rv[1], 32'h40C00000);
            check("bp hold valid", 32'(ov), 32'd3);
            check("bp hold in_ready", 32'(ir), 32'd0);
            check("bp hold exception", 32'(ex), 32'd0);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         check("bp release out_valid", 32'(ov), 32'd0);
         check("bp release in_ready", 32'(ir), 32'd3);
         @(posedge clk);
         #1;
         check("bp second accept busy", 32'(bz), 32'd3);
         check("bp second accept in_ready", 32'(ir), 32'd0);
         in_valid = 1'b0;
         collect("bp second op", 32'hC0100000, 1'b0, 1'b0);
      end

      // Reset mid-operation: B1 is in MULT, B4 is parked in DONE.
      out_ready = 1'b0;
      start_op(32'h40400000, 32'h40000000);
      repeat (9) @(posedge clk);
      #1;
      check("pre-reset B1 busy", 32'(bz[0]), 32'd1);
      check("pre-reset B1 out_valid", 32'(ov[0]), 32'd0);
      check("pre-reset B4 out_valid", 32'(ov[1]), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort out_valid", 32'(ov), 32'd0);
      check("abort exception", 32'(ex), 32'd0);
      check("abort in_ready", 32'(ir), 32'd3);
      check("abort busy", 32'(bz), 32'd0);
      check("abort r B1", rv[0], 32'h0);
      check("abort r B4", rv[1], 32'h0);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      start_op(32'h40400000, 32'h40000000);
      collect("post-reset 3x2", 32'h40C00000, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
